// File: rtl/cnn_pkg.sv
// Shared constants and types for the CNN host-side L2 result reader.
package cnn_pkg;

    localparam int NUM_CLASSES_DEF = 10;
    localparam int L2_ADDR_W       = 4;
    localparam int L2_DATA_W       = 32;

    typedef enum logic [2:0] {IDLE, ARM, RUN, READ, LAST, OUT} rdr_state_t;

    typedef logic signed [31:0] score_t;

endpackage

// File: rtl/l2_argmax_acc.sv
// Running signed maximum with index; the first element loads unconditionally,
// later elements replace it only when strictly greater (lowest index wins ties).
module l2_argmax_acc
    import cnn_pkg::*;
#(
    parameter int DATA_W = L2_DATA_W,
    parameter int ADDR_W = L2_ADDR_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     first,
    input  logic                     valid,
    input  logic signed [DATA_W-1:0] data,
    input  logic        [ADDR_W-1:0] idx,
    output logic signed [DATA_W-1:0] max,
    output logic        [ADDR_W-1:0] max_idx
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            max     <= '0;
            max_idx <= '0;
        end else if (valid && (first || (data > max))) begin
            max     <= data;
            max_idx <= idx;
        end
    end

endmodule

// File: rtl/l2_result_reader.sv
// Host-side reader: launches the engine, reads NUM_CLASSES scores from L2 and
// presents the argmax on a valid/ready handshake. Optional macro: L2_SCORE_STREAM_EN.
module l2_result_reader
    import cnn_pkg::*;
#(
    parameter int NUM_CLASSES = NUM_CLASSES_DEF,
    parameter int ADDR_W      = L2_ADDR_W,
    parameter int DATA_W      = L2_DATA_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    output logic                     ready,
    input  logic                     busy,
    output logic                     oe_L2,
    output logic        [ADDR_W-1:0] addr_L2,
    input  logic signed [DATA_W-1:0] r_data_L2,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic        [ADDR_W-1:0] class_idx,
    output logic signed [DATA_W-1:0] class_score,
`ifdef L2_SCORE_STREAM_EN
    output logic                     score_valid,
    output logic signed [DATA_W-1:0] score_data,
`endif
    output logic                     done
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_CLASSES - 1);

    rdr_state_t        state, state_nxt;
    logic [ADDR_W-1:0] addr_q;
    logic              cmp_valid;
    logic              cmp_first;
    logic [ADDR_W-1:0] cmp_idx;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            addr_q <= '0;
        end else if (state == RUN) begin
            addr_q <= '0;
        end else if ((state == READ) && (addr_q != LAST_ADDR)) begin
            addr_q <= addr_q + ADDR_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        ready     = 1'b0;
        oe_L2     = 1'b0;
        res_valid = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: if (start) state_nxt = ARM;
            ARM: begin
                ready = 1'b1;
                if (busy) state_nxt = RUN;
            end
            RUN: if (!busy) state_nxt = READ;
            READ: begin
                oe_L2 = 1'b1;
                if (addr_q == LAST_ADDR) state_nxt = LAST;
            end
            LAST: state_nxt = OUT;
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    done      = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Read data lags the address by one cycle, so the element under compare is
    // the previous address in READ and the held final address in LAST.
    always_comb begin
        cmp_valid = ((state == READ) && (addr_q != '0)) || (state == LAST);
        cmp_idx   = (state == LAST) ? addr_q : (addr_q - ADDR_W'(1));
        cmp_first = (cmp_idx == '0);
    end

    assign addr_L2 = addr_q;

    l2_argmax_acc #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_acc (
        .clk     (clk),
        .reset   (reset),
        .first   (cmp_first),
        .valid   (cmp_valid),
        .data    (r_data_L2),
        .idx     (cmp_idx),
        .max     (class_score),
        .max_idx (class_idx)
    );

`ifdef L2_SCORE_STREAM_EN
    assign score_valid = cmp_valid;
    assign score_data  = r_data_L2;
`endif

endmodule

// File: tb/tb_l2_result_reader.sv
// Directed self-checking bench for l2_result_reader with a behavioural L2 memory.
module tb_l2_result_reader;
    import cnn_pkg::*;

    localparam int NC = 10;
    localparam int AW = 4;
    localparam int DW = 32;

    logic                 clk       = 1'b0;
    logic                 reset     = 1'b0;
    logic                 start     = 1'b0;
    logic                 busy      = 1'b0;
    logic                 res_ready = 1'b1;
    logic                 ready, oe_L2, res_valid, done;
    logic        [AW-1:0] addr_L2, class_idx;
    logic signed [DW-1:0] r_data_L2 = '0;
    logic signed [DW-1:0] class_score;
`ifdef L2_SCORE_STREAM_EN
    logic                 score_valid;
    logic signed [DW-1:0] score_data;
    score_t               stream_q[$];
`endif

    score_t mem [0:15];
    int     n_checks = 0;
    int     n_fail   = 0;
    int     done_cnt = 0;

    l2_result_reader #(
        .NUM_CLASSES (NC),
        .ADDR_W      (AW),
        .DATA_W      (DW)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .ready       (ready),
        .busy        (busy),
        .oe_L2       (oe_L2),
        .addr_L2     (addr_L2),
        .r_data_L2   (r_data_L2),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .class_idx   (class_idx),
        .class_score (class_score),
`ifdef L2_SCORE_STREAM_EN
        .score_valid (score_valid),
        .score_data  (score_data),
`endif
        .done        (done)
    );

    always #5 clk = ~clk;

    always @(posedge clk) if (oe_L2) r_data_L2 <= mem[addr_L2];

    always @(negedge clk) if (done) done_cnt = done_cnt + 1;

`ifdef L2_SCORE_STREAM_EN
    always @(negedge clk) if (score_valid) stream_q.push_back(score_data);
`endif

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic load_scores(input score_t v [NC]);
        for (int i = 0; i < 16; i++) mem[i] = (i < NC) ? v[i] : 32'sh5A5A_5A5A;
    endtask

    task automatic run_once(input int busy_len);
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; busy = 1'b1;
        repeat (busy_len) @(negedge clk);
        busy = 1'b0;
    endtask

    task automatic wait_valid(output int lat);
        lat = 0;
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic test_reset;
        #12;
        n_checks++;
        if ({ready, oe_L2, res_valid, done} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_ctrl: got %b expected 0000", {ready, oe_L2, res_valid, done});
        end
        n_checks++;
        if (addr_L2 !== '0 || class_idx !== '0) begin
            n_fail++;
            $display("FAIL reset_addr_idx: got addr=%0d idx=%0d expected 0/0", addr_L2, class_idx);
        end
        n_checks++;
        if (class_score !== '0) begin
            n_fail++;
            $display("FAIL reset_score: got %0d expected 0", class_score);
        end
        @(negedge clk); reset = 1'b1;
        repeat (3) @(negedge clk);
        n_checks++;
        if (ready !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_hold: got ready=%b res_valid=%b expected 0/0", ready, res_valid);
        end
    endtask

    task automatic test_basic;
        score_t v [NC];
        int lat, d0;
        v = '{32'sd5, -32'sd3, 32'sd12, 32'sd7, 32'sd0, 32'sd12, -32'sd1, 32'sd2, 32'sd9, 32'sd11};
        load_scores(v);
        res_ready = 1'b1;
        d0 = done_cnt;
        run_once(3);
        wait_valid(lat);
        n_checks++;
        if (lat != NC + 2) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d expected %0d", lat, NC + 2);
        end
        n_checks++;
        if (class_idx !== 4'd2 || class_score !== 32'sd12) begin
            n_fail++;
            $display("FAIL basic_result: got idx=%0d score=%0d expected 2/12", class_idx, class_score);
        end
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL basic_done_now: got %b expected 1", done);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL basic_done_once: got valid=%b pulses=%0d expected 0/1", res_valid, done_cnt - d0);
        end
    endtask

    task automatic test_extremes;
        score_t v [NC];
        int lat;
        res_ready = 1'b1;
        for (int i = 0; i < NC; i++) v[i] = 32'sh8000_0000;
        v[9] = 32'sh8000_0001;
        load_scores(v);
        run_once(2);
        // busy toggles while the scores are read and the result is offered
        lat = 0;
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
            busy = lat[0];
        end
        n_checks++;
        if (lat != NC + 2 || class_idx !== 4'd9 || class_score !== 32'sh8000_0001) begin
            n_fail++;
            $display("FAIL min_scores: got lat=%0d idx=%0d score=%h expected 12/9/80000001", lat, class_idx, class_score);
        end
        @(negedge clk); busy = 1'b0;

        for (int i = 0; i < NC; i++) v[i] = 32'sh8000_0000;
        v[3] = 32'sh7FFF_FFFF;
        v[7] = 32'sh7FFF_FFFF;
        load_scores(v);
        run_once(2);
        wait_valid(lat);
        n_checks++;
        if (class_idx !== 4'd3 || class_score !== 32'sh7FFF_FFFF) begin
            n_fail++;
            $display("FAIL max_tie: got idx=%0d score=%h expected 3/7fffffff", class_idx, class_score);
        end
        @(negedge clk);

        for (int i = 0; i < NC; i++) v[i] = 32'sd0;
        load_scores(v);
        run_once(2);
        wait_valid(lat);
        n_checks++;
        if (class_idx !== 4'd0 || class_score !== 32'sd0) begin
            n_fail++;
            $display("FAIL all_zero: got idx=%0d score=%0d expected 0/0", class_idx, class_score);
        end
        @(negedge clk);
    endtask

    task automatic test_handshake;
        score_t v [NC];
        int lat;
        v = '{32'sd5, -32'sd3, 32'sd12, 32'sd7, 32'sd0, 32'sd12, -32'sd1, 32'sd2, 32'sd9, 32'sd11};
        load_scores(v);
        res_ready = 1'b1;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        n_checks++;
        if (ready !== 1'b1) begin
            n_fail++;
            $display("FAIL arm_ready: got %b expected 1", ready);
        end
        busy = 1'b1;
        @(negedge clk);
        n_checks++;
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_drop: got %b expected 0", ready);
        end
        repeat (48) @(negedge clk);
        n_checks++;
        if (oe_L2 !== 1'b0 || res_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL run_quiet: got oe=%b valid=%b expected 0/0", oe_L2, res_valid);
        end
        @(negedge clk);
        busy = 1'b0;
        @(negedge clk);
        n_checks++;
        if (oe_L2 !== 1'b1 || addr_L2 !== 4'd0) begin
            n_fail++;
            $display("FAIL first_read: got oe=%b addr=%0d expected 1/0", oe_L2, addr_L2);
        end
        lat = 1;
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
        n_checks++;
        if (lat != NC + 2) begin
            n_fail++;
            $display("FAIL hs_latency: got %0d expected %0d", lat, NC + 2);
        end
        @(negedge clk);
    endtask

    task automatic test_backpressure;
        score_t v [NC];
        int lat, d0, bad;
        v = '{-32'sd7, -32'sd7, -32'sd1, -32'sd20, -32'sd1, -32'sd100, -32'sd3, -32'sd1, -32'sd50, -32'sd9};
        load_scores(v);
        res_ready = 1'b0;
        d0 = done_cnt;
        run_once(5);
        wait_valid(lat);
        n_checks++;
        if (lat != NC + 2 || class_idx !== 4'd2 || class_score !== -32'sd1) begin
            n_fail++;
            $display("FAIL bp_result: got lat=%0d idx=%0d score=%0d expected 12/2/-1", lat, class_idx, class_score);
        end
        bad = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (res_valid !== 1'b1 || done !== 1'b0 || class_idx !== 4'd2 || class_score !== -32'sd1) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL bp_hold: got %0d unstable cycles expected 0", bad);
        end
        @(posedge clk); #1 res_ready = 1'b1;
        @(negedge clk);
        n_checks++;
        if (done !== 1'b1) begin
            n_fail++;
            $display("FAIL bp_done: got %b expected 1", done);
        end
        @(negedge clk);
        n_checks++;
        if (res_valid !== 1'b0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL bp_release: got valid=%b pulses=%0d expected 0/1", res_valid, done_cnt - d0);
        end
    endtask

    task automatic test_start_ignored;
        score_t v [NC];
        int lat, d0, bad;
        v = '{32'sd5, -32'sd3, 32'sd12, 32'sd7, 32'sd0, 32'sd12, -32'sd1, 32'sd2, 32'sd9, 32'sd11};
        load_scores(v);
        res_ready = 1'b0;
        d0 = done_cnt;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0; busy = 1'b1;
        repeat (3) @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        repeat (3) @(negedge clk); busy = 1'b0;
        wait_valid(lat);
        n_checks++;
        if (lat != NC + 2 || class_idx !== 4'd2) begin
            n_fail++;
            $display("FAIL start_in_run: got lat=%0d idx=%0d expected 12/2", lat, class_idx);
        end
        start = 1'b1;
        @(negedge clk); start = 1'b0;
        @(posedge clk); #1 res_ready = 1'b1;
        @(negedge clk); @(negedge clk);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ready !== 1'b0 || res_valid !== 1'b0 || oe_L2 !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0 || done_cnt - d0 != 1) begin
            n_fail++;
            $display("FAIL start_in_out: got %0d busy cycles, %0d results expected 0/1", bad, done_cnt - d0);
        end
    endtask

    task automatic test_reset_mid;
        score_t v [NC];
        int bad;
        v = '{32'sd5, -32'sd3, 32'sd12, 32'sd7, 32'sd0, 32'sd12, -32'sd1, 32'sd2, 32'sd9, 32'sd11};
        load_scores(v);
        res_ready = 1'b1;
        run_once(3);
        repeat (3) @(negedge clk);
        n_checks++;
        if (oe_L2 !== 1'b1 || addr_L2 !== 4'd2 || class_score !== 32'sd5) begin
            n_fail++;
            $display("FAIL pre_reset: got oe=%b addr=%0d score=%0d expected 1/2/5", oe_L2, addr_L2, class_score);
        end
        #2 reset = 1'b0;
        #1;
        n_checks++;
        if ({ready, oe_L2, res_valid, done} !== 4'b0000 || addr_L2 !== '0 ||
            class_idx !== '0 || class_score !== '0) begin
            n_fail++;
            $display("FAIL async_reset: got ctrl=%b addr=%0d idx=%0d score=%0d expected all 0",
                     {ready, oe_L2, res_valid, done}, addr_L2, class_idx, class_score);
        end
        @(negedge clk); reset = 1'b1;
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (ready !== 1'b0 || res_valid !== 1'b0 || oe_L2 !== 1'b0) bad++;
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL reset_idle: got %0d active cycles expected 0", bad);
        end
    endtask

`ifdef L2_SCORE_STREAM_EN
    task automatic test_score_stream;
        score_t v [NC];
        int lat, bad;
        v = '{32'sd5, -32'sd3, 32'sd12, 32'sd7, 32'sd0, 32'sd12, -32'sd1, 32'sd2, 32'sd9, 32'sd11};
        load_scores(v);
        res_ready = 1'b1;
        stream_q.delete();
        run_once(3);
        wait_valid(lat);
        @(negedge clk);
        n_checks++;
        if (stream_q.size() != NC) begin
            n_fail++;
            $display("FAIL stream_count: got %0d expected %0d", stream_q.size(), NC);
        end
        bad = 0;
        for (int i = 0; i < NC; i++) if (i >= stream_q.size() || stream_q[i] !== v[i]) bad++;
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL stream_data: got %0d wrong elements expected 0", bad);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_basic;
        test_extremes;
        test_handshake;
        test_backpressure;
        test_start_ignored;
        test_reset_mid;
`ifdef L2_SCORE_STREAM_EN
        test_score_stream;
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
